axi_read_master: RTL and testbench

AXI4 read-burst master sitting directly upstream of `axi_slave_ram`. It accepts one burst command at a time, drives the AR channel, and collects the R beats. Beats pass through a one-entry output register onto a valid/ready stream for a local consumer. It flags response and `rlast` protocol errors and pulses `done` when the burst has fully drained.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_read_master_if.sv | 34 +++
 rtl/axi_beat_reg.sv | 36 +++
 rtl/axi_read_master.sv | 130 +++++++++++++
 tb/tb_axi_read_master.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants and the read-master FSM state type.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // EXOKAY is a successful response; only SLVERR/DECERR are errors.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_read_master_if.sv
// AXI4 AR + R channel bundle between a read master and its slave.
interface axi_read_master_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;

  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_beat_reg.sv
// One-entry valid/ready register carrying a data beat and its last flag.
module axi_beat_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Accepting while draining gives back-to-back beats with no bubble.
  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_read_master.sv
// Single-outstanding AXI4 read-burst master: issues one AR, counts R beats into
// a one-entry output register, flags resp/rlast errors and pulses done on drain.
module axi_read_master
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  axi_read_master_if.master        axi,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic [1:0]               err
);

  state_t                   state;
  state_t                   state_next;
  logic                     cmd_ready_q;
  logic                     done_q;
  logic [1:0]               err_q;
  logic [ADDRESS_WIDTH-1:0] araddr_q;
  logic [7:0]               arlen_q;
  logic [2:0]               arsize_q;
  logic [1:0]               arburst_q;
  logic [7:0]               beat_cnt;
  logic                     all_captured;
  logic                     arvalid_c;
  logic                     rready_c;
  logic                     beat_in_ready;
  logic                     cmd_fire;
  logic                     beat_fire;
  logic                     is_final;
  logic                     drain_final;

  assign cmd_fire    = cmd_valid && cmd_ready_q;
  assign beat_fire   = axi.rvalid && rready_c;
  assign is_final    = (beat_cnt == arlen_q);
  assign drain_final = out_valid && out_ready && out_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    arvalid_c  = 1'b0;
    rready_c   = 1'b0;
    case (state)
      ST_IDLE: if (cmd_fire) state_next = ST_ADDR;
      ST_ADDR: begin
        arvalid_c = 1'b1;
        if (axi.arready) state_next = ST_DATA;
      end
      ST_DATA: begin
        // Burst length comes from the latched count, never from rlast.
        rready_c = !all_captured && beat_in_ready;
        if (drain_final) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      beat_cnt     <= '0;
      all_captured <= 1'b0;
    end else begin
      cmd_ready_q <= (state_next == ST_IDLE);
      done_q      <= (state == ST_DATA) && drain_final;
      if (cmd_fire) begin
        araddr_q     <= cmd_addr;
        arlen_q      <= cmd_len;
        arsize_q     <= cmd_size;
        arburst_q    <= cmd_burst;
        beat_cnt     <= '0;
        all_captured <= 1'b0;
        err_q        <= '0;
      end
      if (beat_fire) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (is_final)                   all_captured <= 1'b1;
        if (resp_is_error(axi.rresp))   err_q[0]     <= 1'b1;
        if (axi.rlast != is_final)      err_q[1]     <= 1'b1;
      end
    end
  end

  axi_beat_reg #(.DATA_WIDTH(DATA_WIDTH)) u_beat_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   (axi.rdata),
    .in_last   (is_final),
    .in_valid  (beat_fire),
    .in_ready  (beat_in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;
  assign cmd_ready   = cmd_ready_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_axi_read_master.sv
// Directed bench for axi_read_master with a behavioural RAM slave whose beat
// data is 0x100000AA, AA being the beat's byte address.
module tb_axi_read_master;

  logic        aclk;
  logic        aresetn;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic [1:0]  err;

  axi_read_master_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_read_master #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .axi       (bus),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .err       (err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1);
  end

  // Slave model: observes handshakes mid-low-phase, updates outputs just after posedge.
  int          ar_stall = 0;
  int          err_beat = -1;
  int          bad_last_beat = -1;
  bit          s_active, s_ar_hs, s_r_hs, s_ar_wait_cyc;
  logic [7:0]  s_addr, s_len, s_cap_addr, s_cap_len, s_baddr;
  logic [2:0]  s_size, s_cap_size;
  logic [1:0]  s_burst, s_cap_burst;
  int          s_beat, s_ar_wait;

  initial begin
    s_active = 0; s_beat = 0; s_ar_wait = 0;
    s_addr = '0; s_len = '0; s_size = '0; s_burst = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
    forever begin
      @(negedge aclk); #1;
      s_ar_hs       = bus.arvalid && bus.arready;
      s_r_hs        = bus.rvalid && bus.rready;
      s_ar_wait_cyc = bus.arvalid && !bus.arready;
      s_cap_addr = bus.araddr; s_cap_len = bus.arlen;
      s_cap_size = bus.arsize; s_cap_burst = bus.arburst;
      @(posedge aclk); #1;
      if (!aresetn) begin
        s_active = 0; s_beat = 0; s_ar_wait = 0;
      end else begin
        if (s_ar_hs) begin
          s_active = 1; s_beat = 0; s_ar_wait = 0;
          s_addr = s_cap_addr; s_len = s_cap_len; s_size = s_cap_size; s_burst = s_cap_burst;
        end else if (s_ar_wait_cyc) begin
          s_ar_wait++;
        end
        if (s_r_hs) begin
          s_beat++;
          if (s_beat > int'(s_len)) s_active = 0;
        end
      end
      s_baddr     = (s_burst == 2'd0) ? s_addr : s_addr + 8'(s_beat << s_size);
      bus.arready = !s_active && (s_ar_wait >= ar_stall);
      bus.rvalid  = s_active;
      bus.rdata   = {24'h100000, s_baddr};
      bus.rresp   = (s_beat == err_beat) ? 2'd2 : 2'd0;
      bus.rlast   = s_active && ((s_beat == int'(s_len)) || (s_beat == bad_last_beat));
    end
  end

  // Monitor: records drained beats and AR handshakes, checks done timing and stall behaviour.
  int          exp_beats = 0;
  int          done_cnt = 0;
  int          ar_count = 0;
  logic [21:0] ar_seen;
  logic [31:0] got_data[$];
  logic        got_last[$];
  bit          done_due = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_data;

  initial begin
    forever begin
      @(negedge aclk); #1;
      if (!aresetn) begin
        done_due = 0; stall_prev = 0;
      end else begin
        check("done_timing", done, done_due);
        if (done === 1'b1) begin
          done_cnt++;
          check("cmd_ready_with_done", cmd_ready, 1);
        end
        done_due = 0;
        if (stall_prev) check("out_stable", {out_valid, out_data}, {1'b1, stall_data});
        if (out_valid && !out_ready) check("rready_hold", bus.rready, 0);
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (out_valid && out_ready) begin
          got_data.push_back(out_data);
          got_last.push_back(out_last);
          if (got_data.size() == exp_beats) done_due = 1;
        end
        if (bus.arvalid && bus.arready) begin
          ar_count++;
          ar_seen = {bus.araddr, bus.arlen, bus.arsize, bus.arburst};
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("arvalid_t1", bus.arvalid, 1);
    check("cmd_ready_low_t1", cmd_ready, 0);
    check("err_cleared_on_accept", err, 0);
    check("ar_payload_t1", {bus.araddr, bus.arlen, bus.arsize, bus.arburst}, {addr, len, size, burst});
  endtask

  task automatic wait_done(input int target, input bit bp);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (done_cnt < target && n < 300) begin
      out_ready = bp ? pat[n % 4] : 1'b1;
      @(negedge aclk);
      n++;
    end
    out_ready = 1'b1;
    check("done_seen", done_cnt, target);
    repeat (2) @(negedge aclk);
  endtask

  task automatic check_beats(input logic [7:0] base, input int n);
    logic [7:0] a;
    check("beat_count", got_data.size(), n);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      a = base + 8'(4 * i);
      check($sformatf("beat%0d_data", i), got_data[i], {24'h100000, a});
      check($sformatf("beat%0d_last", i), got_last[i], (i == n - 1));
    end
  endtask

  task automatic run_burst(input logic [7:0] addr, input logic [7:0] len, input bit bp);
    int d0;
    got_data.delete();
    got_last.delete();
    exp_beats = int'(len) + 1;
    d0 = done_cnt;
    send_cmd(addr, len, 3'd2, 2'd1);
    wait_done(d0 + 1, bp);
  endtask

  initial begin
    int a0, d0, n;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0; out_ready = 1'b0;

    // Reset held for three cycles: every output low.
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_rready", bus.rready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_out_data", {out_data, out_last}, 0);
    check("rst_araddr", {bus.araddr, bus.arlen}, 0);
    aresetn = 1'b1;
    check("cmd_ready_before_edge", cmd_ready, 0);
    @(negedge aclk);
    check("cmd_ready_after_release", cmd_ready, 1);

    // Plain INCR burst, addr 0, 4 beats of 4 bytes.
    out_ready = 1'b1;
    a0 = ar_count;
    run_burst(8'h00, 8'd3, 1'b0);
    check("incr_ar_count", ar_count - a0, 1);
    check("incr_ar_payload", ar_seen, {8'h00, 8'd3, 3'd2, 2'd1});
    check_beats(8'h00, 4);
    check("incr_err", err, 0);

    // Same burst under out_ready pattern 1,0,0,1.
    run_burst(8'h00, 8'd3, 1'b1);
    check_beats(8'h00, 4);
    check("bp_err", err, 0);

    // AR stalled for five cycles.
    ar_stall = 5;
    a0 = ar_count;
    got_data.delete(); got_last.delete();
    exp_beats = 2;
    d0 = done_cnt;
    send_cmd(8'h40, 8'd1, 3'd2, 2'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_ar", i), {bus.arvalid, bus.araddr, bus.arlen, bus.arsize, bus.arburst},
            {1'b1, 8'h40, 8'd1, 3'd2, 2'd1});
      check($sformatf("stall%0d_rready", i), bus.rready, 0);
      @(negedge aclk);
    end
    check("stall6_arvalid", bus.arvalid, 1);
    check("stall6_no_hs_yet", ar_count - a0, 0);
    @(negedge aclk);
    check("stall_arvalid_dropped", bus.arvalid, 0);
    check("stall_hs_count", ar_count - a0, 1);
    ar_stall = 0;
    wait_done(d0 + 1, 1'b0);
    check_beats(8'h40, 2);

    // SLVERR on beat 1, early rlast on beat 2.
    err_beat = 1;
    bad_last_beat = 2;
    run_burst(8'h10, 8'd3, 1'b0);
    err_beat = -1;
    bad_last_beat = -1;
    check("errinj_err", err, 2'b11);
    check_beats(8'h10, 4);

    // Reset after two of eight beats; send_cmd also checks err is cleared.
    got_data.delete(); got_last.delete();
    exp_beats = 8;
    d0 = done_cnt;
    send_cmd(8'h80, 8'd7, 3'd2, 2'd1);
    n = 0;
    while (got_data.size() < 2 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("midrst_two_beats", got_data.size() >= 2, 1);
    aresetn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_rready", bus.rready, 0);
    check("midrst_arvalid", bus.arvalid, 0);
    check("midrst_done", done, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("midrst_no_done", done_cnt, d0);
    check("midrst_cmd_ready_back", cmd_ready, 1);

    // Fresh single-beat command after the reset.
    run_burst(8'hC0, 8'd0, 1'b0);
    check_beats(8'hC0, 1);
    check("post_rst_err", err, 0);
    check("total_done", done_cnt, d0 + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
